sopc_button_pio_in: RTL
=======================

# sopc_button_pio_in

Avalon-MM slave input PIO for the Nios II SOPC system: samples external push-button inputs, synchronises and debounces each bit, latches selected edges into an edge-capture register and raises a maskable interrupt to the CPU. It is the read-direction counterpart of the LED output PIO on the same system interconnect. It uses the same zero-wait-state slave register access and combinational `readdata`.

## Interface
Parameters:
- `WIDTH`, 4: number of input bits, 1..32.
- `DEBOUNCE_CYCLES`, 50000: stable-sample cycles required before a bit change is accepted, ≥1. 50000 is 1 ms at 50 MHz.
- `EDGE_TYPE`, 0: edge that sets capture. 0 = falling, 1 = rising, 2 = any.
- `IDLE_LEVEL`, 1: reset value of every debounced bit. 1 suits active-low buttons.

Ports:
- `clk`: input, 1 bit. System clock.
- `reset_n`: input, 1 bit. Asynchronous, active-low reset.
- `address`: input, 2 bits. Register select.
- `chipselect`: input, 1 bit. Slave select.
- `write_n`: input, 1 bit. Active-low write strobe.
- `writedata`: input, 32 bits. Write data.
- `in_port`: input, `WIDTH` bits. Raw asynchronous button inputs.
- `readdata`: output, 32 bits. Read data. Combinational, zero wait states.
- `irq`: output, 1 bit. Level interrupt, active-high.

## Operation
- Register map. Upper bits `[31:WIDTH]` always read 0.
  - Address 0, data: RO, debounced value `stable`. Writes are ignored.
  - Address 1, irqmask: RW, `WIDTH` bits.
  - Address 2: reserved. Reads 0, writes are ignored.
  - Address 3, edgecapture: RW1C. A write clears each bit where `writedata[i]=1`.
- A write occurs when `chipselect && !write_n`. `readdata` is decoded from `address` alone, gated by nothing.
- Per-bit pipeline:
  - Synchroniser: two flops, `sync1` then `sync2`.
  - Debounce counter `cnt[i]`, width `clog2(DEBOUNCE_CYCLES)`, minimum 1.
  - Debounced register `stable[i]`.
- Debounce rule, evaluated at each clock edge:
  - If `sync2[i] == stable[i]`, then `cnt[i] <= 0`.
  - Else if `cnt[i] == DEBOUNCE_CYCLES-1`, then `stable[i] <= sync2[i]` and `cnt[i] <= 0`.
  - Else `cnt[i] <= cnt[i]+1`.
  - A glitch shorter than `DEBOUNCE_CYCLES` cycles at `sync2` resets the count. It never reaches `stable`.
- Edge event: `ev[i]` is asserted on the edge where `stable[i]` updates.
  - Falling: new value 0.
  - Rising: new value 1.
  - Any: either.
- Capture: `edgecapture[i] <= 1` on `ev[i]`; it is cleared only by an RW1C write.
- Simultaneous set and clear on the same bit in the same cycle: set wins, so the bit stays 1.
- `irq = |(edgecapture & irqmask)`. It is combinational from registers, so there is no glitch from `in_port`.

## Timing
- Reset values, asynchronous, while `reset_n=0`:
  - `sync1`, `sync2`, `stable` = `{WIDTH{IDLE_LEVEL}}`.
  - `cnt` = 0, `irqmask` = 0, `edgecapture` = 0.
  - `irq` = 0. `readdata` at address 0 = `IDLE_LEVEL` pattern.
- Reset asserted mid-debounce discards the pending change. Reset release produces no edge event if `in_port` equals `IDLE_LEVEL`.
- Latency: `in_port[i]` changes and is held before edge E1.
  - `sync2` takes the new value at E2.
  - `stable`, the `edgecapture` set and the `irq` assertion happen at edge E(2+`DEBOUNCE_CYCLES`).
  - Example: `DEBOUNCE_CYCLES=1` updates at E3.
- Register write to irqmask or edgecapture takes effect at the same edge. `irq` follows combinationally after that edge.
- Read: `readdata` is valid in the cycle `address` is presented. Reads have no side effects.

## Test plan
Run with `WIDTH=4`, `DEBOUNCE_CYCLES=4`, `EDGE_TYPE=0`, `IDLE_LEVEL=1`.
- Reset: hold `reset_n=0` with `in_port=4'hF`, then release.
  - Read address 0 returns 32'h0000000F.
  - Addresses 1, 2 and 3 read 0. `irq=0`.
- Debounce latency: drive `in_port=4'hE` held before E1.
  - Address 0 reads 0xF through E5.
  - Address 0 reads 0xE and `edgecapture=0x1` after E6. `irq` stays 0 because the mask is 0.
- Glitch reject: pulse `in_port[1]=0` for 3 cycles, then restore.
  - `stable` and `edgecapture` are unchanged. `irq=0`.
- IRQ and clear:
  - Write irqmask=0x1 with `edgecapture[0]` set: `irq=1` the cycle after the write edge.
  - Write address 3 with 0x1: `edgecapture=0`, `irq=0`.
  - Write 0x2 to address 3 instead: bit 0 stays set.
- Edge polarity: release bit 0 from 0 to 1. `edgecapture` is unchanged because the block is in falling mode.
- Simultaneous: schedule an RW1C write of 0xF on the same edge as a new falling event on bit 2.
  - `edgecapture` becomes 0x4 and `irq` follows the mask.
- Reset mid-operation: assert `reset_n` two cycles into a debounce.
  - All registers return to reset values. No event is captured after release.

Source files
------------

// File: rtl/sopc_button_pio_in.sv
// Avalon-MM input PIO: synchronises and debounces push-button inputs, captures
// selected edges in an RW1C register and raises a maskable level interrupt.
module sopc_button_pio_in #(
  parameter int WIDTH           = 4,
  parameter int DEBOUNCE_CYCLES = 50000,
  parameter int EDGE_TYPE       = 0,
  parameter int IDLE_LEVEL      = 1
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic [1:0]        address,
  input  logic              chipselect,
  input  logic              write_n,
  input  logic [31:0]       writedata,
  input  logic [WIDTH-1:0]  in_port,
  output logic [31:0]       readdata,
  output logic              irq
);

  localparam int CNT_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [WIDTH-1:0] IDLE_VEC = {WIDTH{1'(IDLE_LEVEL)}};

  localparam logic [1:0] ADDR_DATA    = 2'd0;
  localparam logic [1:0] ADDR_IRQMASK = 2'd1;
  localparam logic [1:0] ADDR_EDGECAP = 2'd3;

  logic [WIDTH-1:0] sync1_q, sync1_d;
  logic [WIDTH-1:0] sync2_q, sync2_d;
  logic [WIDTH-1:0] stable_q, stable_d;
  logic [CNT_W-1:0] cnt_q [WIDTH];
  logic [CNT_W-1:0] cnt_d [WIDTH];
  logic [WIDTH-1:0] irqmask_q, irqmask_d;
  logic [WIDTH-1:0] edgecap_q, edgecap_d;

  logic [WIDTH-1:0] upd;
  logic [WIDTH-1:0] ev;
  logic [WIDTH-1:0] clr;
  logic             wr_en;
  logic             wdata_unused;

  assign wr_en        = chipselect & ~write_n;
  assign wdata_unused = ^writedata;

  always_comb begin
    sync1_d  = in_port;
    sync2_d  = sync1_q;
    stable_d = stable_q;
    upd      = '0;
    for (int i = 0; i < WIDTH; i++) begin
      cnt_d[i] = '0;
      // A change must persist for DEBOUNCE_CYCLES edges; any return to the
      // stable level drops the count back to zero.
      if (sync2_q[i] != stable_q[i]) begin
        if (cnt_q[i] == CNT_MAX) begin
          stable_d[i] = sync2_q[i];
          upd[i]      = 1'b1;
        end else begin
          cnt_d[i] = cnt_q[i] + CNT_W'(1);
        end
      end
    end
  end

  always_comb begin
    case (EDGE_TYPE)
      0:       ev = upd & ~stable_d;
      1:       ev = upd & stable_d;
      default: ev = upd;
    endcase
  end

  // Clear is applied before set so a new event in the same cycle survives.
  always_comb begin
    irqmask_d = irqmask_q;
    clr       = '0;
    if (wr_en && address == ADDR_IRQMASK) irqmask_d = writedata[WIDTH-1:0];
    if (wr_en && address == ADDR_EDGECAP) clr = writedata[WIDTH-1:0];
    edgecap_d = (edgecap_q & ~clr) | ev;
  end

  always_comb begin
    readdata = '0;
    case (address)
      ADDR_DATA:    readdata[WIDTH-1:0] = stable_q;
      ADDR_IRQMASK: readdata[WIDTH-1:0] = irqmask_q;
      ADDR_EDGECAP: readdata[WIDTH-1:0] = edgecap_q;
      default:      readdata = '0;
    endcase
  end

  assign irq = |(edgecap_q & irqmask_q);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync1_q   <= IDLE_VEC;
      sync2_q   <= IDLE_VEC;
      stable_q  <= IDLE_VEC;
      irqmask_q <= '0;
      edgecap_q <= '0;
      for (int i = 0; i < WIDTH; i++) cnt_q[i] <= '0;
    end else begin
      sync1_q   <= sync1_d;
      sync2_q   <= sync2_d;
      stable_q  <= stable_d;
      irqmask_q <= irqmask_d;
      edgecap_q <= edgecap_d;
      for (int i = 0; i < WIDTH; i++) cnt_q[i] <= cnt_d[i];
    end
  end

endmodule
